// File: rtl/register.sv
// General-purpose register bank: 2**ADDR_W words of WIDTH bits.
// One synchronous write port and two independent combinational read ports.
module register #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  d_in,
    output logic [WIDTH-1:0]  d_out_a,
    output logic [WIDTH-1:0]  d_out_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Reset wins over a same-cycle write. The write is gated by wr first, so
    // unknown address or data bits while idle never reach the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr) begin
            r_mem[wr_addr] <= d_in;
        end
    end

    // No bypass: a read of the address being written shows the old value
    // until the edge that commits the write.
    assign d_out_a = r_mem[rd_addr_a];
    assign d_out_b = r_mem[rd_addr_b];

endmodule

// File: tb/tb_register.sv
// Directed bench for the register bank: a reference array supplies expected
// read values, which pass through a queue before being compared with the DUT.
module tb_register;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;

    logic [15:0] mdl [8];
    logic [15:0] exp_q [$];
    int          checks;
    int          failures;

    register #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: pop the oldest expectation and compare with an observed value.
    task automatic compare(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: observed=%h but expected queue empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    // Drive both read addresses, queue model values, then compare outputs.
    task automatic check_ports(input logic [2:0] a, input logic [2:0] b, input string tag);
        rd_addr_a = a;
        rd_addr_b = b;
        exp_q.push_back(mdl[a]);
        exp_q.push_back(mdl[b]);
        #1;
        compare({tag, "_a"}, d_out_a);
        compare({tag, "_b"}, d_out_b);
    endtask

    // One clocked cycle with the current inputs; the model follows the edge.
    task automatic clock_edge();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        end else if (wr) begin
            mdl[wr_addr] = d_in;
        end
        #1;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
        wr      = 1'b1;
        wr_addr = addr;
        d_in    = data;
        clock_edge();
        wr      = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        wr        = 1'b0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_addr   = 3'd0;
        d_in      = 16'h0000;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;

        // Reset: every address reads zero on both ports.
        clock_edge();
        clock_edge();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) check_ports(3'(i), 3'(7 - i), "reset_sweep");
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h0000);
            rd_addr_a = 3'(i);
            #1;
            compare("reset_zero_const", d_out_a);
        end

        // Write then read back on both ports, while another write is pending.
        do_write(3'd3, 16'hcdef);
        do_write(3'd7, 16'h3210);
        wr      = 1'b1;
        wr_addr = 3'd5;
        d_in    = 16'h4567;
        exp_q.push_back(16'hcdef);
        exp_q.push_back(16'h3210);
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd7;
        #1;
        compare("rd_r3", d_out_a);
        compare("rd_r7", d_out_b);
        clock_edge();
        wr = 1'b0;

        // Unwritten register, R0 write, idle cycle with unknown data.
        wr      = 1'b1;
        wr_addr = 3'd0;
        d_in    = 16'hba98;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h4567);
        rd_addr_a = 3'd1;
        rd_addr_b = 3'd5;
        #1;
        compare("rd_r1_unwritten", d_out_a);
        compare("rd_r5", d_out_b);
        clock_edge();
        wr      = 1'b0;
        wr_addr = 3'd1;
        d_in    = 16'hxxxx;
        clock_edge();
        clock_edge();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h4567);
        #1;
        compare("idle_r1_hold", d_out_a);
        compare("idle_r5_hold", d_out_b);
        exp_q.push_back(16'hba98);
        exp_q.push_back(16'hba98);
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        #1;
        compare("r0_a", d_out_a);
        compare("r0_b", d_out_b);

        // Read-during-write: old value before the edge, new value right after.
        do_write(3'd2, 16'h1111);
        rd_addr_a = 3'd2;
        wr        = 1'b1;
        wr_addr   = 3'd2;
        d_in      = 16'h2222;
        exp_q.push_back(16'h1111);
        #1;
        compare("rdw_before", d_out_a);
        clock_edge();
        wr = 1'b0;
        exp_q.push_back(16'h2222);
        compare("rdw_after", d_out_a);

        // Reset pulse between edges must not disturb contents.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) check_ports(3'(i), 3'(i), "mid_reset_hold");

        // Reset held across an edge beats a concurrent write to R4.
        reset   = 1'b1;
        wr      = 1'b1;
        wr_addr = 3'd4;
        d_in    = 16'hffff;
        clock_edge();
        reset = 1'b0;
        wr    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h0000);
            rd_addr_a = 3'(i);
            #1;
            compare("reset_priority", d_out_a);
        end

        // Address sweep with independent port addresses.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h1000 + 16'(i));
            exp_q.push_back(16'h1000 + 16'(7 - i));
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            compare("sweep_a", d_out_a);
            compare("sweep_b", d_out_b);
        end

        // Random writes and reads against the reference array.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
            end else begin
                clock_edge();
            end
            check_ports(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
